prefix_adder_pipe: RTL and testbench

Parametrised, pipelined Ladner-Fischer prefix adder/subtractor with valid/ready handshakes on input and output. It generalises the 32-bit combinational prefix adder to any power-of-two width, with configurable register placement between prefix levels. It adds a subtract mode with borrow chaining, and signed-overflow and zero flags. It is intended as the ALU add path and as a multi-word arithmetic building block.

---
 rtl/prefix_adder_pkg.sv | 63 ++++++
 rtl/pg_cell.sv | 13 +
 rtl/prefix_level.sv | 26 ++
 rtl/prefix_adder_pipe.sv | 180 ++++++++++++++++++
 tb/tb_prefix_adder_pipe.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined prefix adder.
package prefix_adder_pkg;

   // Propagate/generate pair carried through the prefix network.
   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   // Number of Ladner-Fischer levels for an n-bit operand (log2 of n).
   function automatic int unsigned lf_levels(input int unsigned n);
      int unsigned l;
      l = 32'd0;
      for (int unsigned i = 32'd0; i < 32'd31; i++) begin
         if ((32'd1 << i) < n) begin
            l = i + 32'd1;
         end else begin
            l = l;
         end
      end
      return l;
   endfunction

   // Width must be a power of two and at least 4.
   function automatic bit n_is_valid(input int unsigned n);
      return (n >= 32'd4) && ((n & (n - 32'd1)) == 32'd0);
   endfunction

   // Levels per rank, clamped into 1..L.
   function automatic int unsigned k_eff(input int unsigned n, input int unsigned k);
      int unsigned l;
      l = lf_levels(n);
      if (k < 32'd1) begin
         return 32'd1;
      end else if (k > l) begin
         return l;
      end else begin
         return k;
      end
   endfunction

   // Input-to-output latency: one rank per K levels plus the result rank.
   function automatic int unsigned lat(input int unsigned n, input int unsigned k);
      int unsigned l;
      int unsigned ke;
      l  = lf_levels(n);
      ke = k_eff(n, k);
      return ((l + ke - 32'd1) / ke) + 32'd1;
   endfunction

   // Index of the last prefix level feeding rank r (0-based rank index).
   function automatic int unsigned rank_src(input int unsigned r, input int unsigned ke,
                                            input int unsigned l);
      int unsigned last;
      last = (r + 32'd1) * ke;
      if (last < l) begin
         return last - 32'd1;
      end else begin
         return l - 32'd1;
      end
   endfunction

endpackage

// File: rtl/pg_cell.sv
// Black cell of the prefix network: merges a high group with the adjacent lower group.
module pg_cell
   import prefix_adder_pkg::*;
(
   input  pg_t hi,
   input  pg_t lo,
   output pg_t pg_out
);

   assign pg_out.g = hi.g | (hi.p & lo.g);
   assign pg_out.p = hi.p & lo.p;

endmodule

// File: rtl/prefix_level.sv
// One combinational Ladner-Fischer row. At level LEVEL every bit whose LEVEL-th index
// bit is set merges with the top bit of the preceding 2**LEVEL block; others pass through.
module prefix_level
   import prefix_adder_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned LEVEL = 0
) (
   input  pg_t [N-1:0] pg_in,
   output pg_t [N-1:0] pg_out
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> LEVEL) & 1) == 1) begin : g_black
         localparam int J = ((i >> LEVEL) << LEVEL) - 1;
         pg_cell u_cell (
            .hi     (pg_in[i]),
            .lo     (pg_in[J]),
            .pg_out (pg_out[i])
         );
      end else begin : g_pass
         assign pg_out[i] = pg_in[i];
      end
   end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Ladner-Fischer adder/subtractor with valid/ready on both sides.
// The carry-in is kept out of the prefix tree and applied in the final rank
// (carry into bit i+1 = G[i] | P[i] & cin), which equals treating it as a
// generate at position -1.
module prefix_adder_pipe
   import prefix_adder_pkg::*;
#(
   parameter int unsigned N = 32,
   parameter int unsigned K = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         op_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         ovf,
   output logic         zero,
   output logic         busy
);

   localparam int unsigned L   = lf_levels(N);
   localparam int unsigned KE  = k_eff(N, K);
   localparam int unsigned LAT = lat(N, K);
   localparam int unsigned R   = LAT - 32'd1;

   if (!n_is_valid(N)) begin : g_bad_n
      $error("prefix_adder_pipe: N must be a power of two and at least 4");
   end

   logic [N-1:0] bb_s;
   logic         cin_eff_s;
   pg_t  [N-1:0] pg0_s;
   pg_t  [N-1:0] lvl_in_s  [L];
   pg_t  [N-1:0] lvl_out_s [L];
   pg_t  [N-1:0] rank_pg_r [R];
   logic [N-1:0] rank_hs_r [R];
   logic         rank_cin_r [R];
   logic [N-1:0] rank_hs_in_s [R];
   logic         rank_cin_in_s [R];
   logic [LAT-1:0] v_r;
   logic [LAT-1:0] adv_s;
   logic [LAT-1:0] load_s;
   logic         in_ready_s;
   logic [N-1:0] fin_p_s;
   logic [N-1:0] fin_g_s;
   logic [N:0]   cy_s;
   logic [N-1:0] sum_s;
   logic         c_out_s;
   logic         ovf_s;
   logic         zero_s;
   logic [N-1:0] sum_r;
   logic         c_out_r;
   logic         ovf_r;
   logic         zero_r;

   // Operand prep: subtraction is a + ~b + ~borrow_in.
   always_comb begin
      if (op_sub) begin
         bb_s      = ~b;
         cin_eff_s = ~c_in;
      end else begin
         bb_s      = b;
         cin_eff_s = c_in;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_bit_pg
      assign pg0_s[i].p = a[i] | bb_s[i];
      assign pg0_s[i].g = a[i] & bb_s[i];
   end

   // Prefix rows; a row that starts a new rank reads that rank's register.
   for (genvar l = 0; l < L; l++) begin : g_lvl
      if (l == 0) begin : g_from_prep
         assign lvl_in_s[l] = pg0_s;
      end else if ((l % KE) == 0) begin : g_from_rank
         assign lvl_in_s[l] = rank_pg_r[(l / KE) - 1];
      end else begin : g_from_row
         assign lvl_in_s[l] = lvl_out_s[l - 1];
      end
      prefix_level #(
         .N     (N),
         .LEVEL (l)
      ) u_level (
         .pg_in  (lvl_in_s[l]),
         .pg_out (lvl_out_s[l])
      );
   end

   for (genvar r = 0; r < R; r++) begin : g_rank
      localparam int unsigned SRC = rank_src(r, KE, L);
      if (r == 0) begin : g_first
         assign rank_hs_in_s[r]  = a ^ bb_s;
         assign rank_cin_in_s[r] = cin_eff_s;
      end else begin : g_next
         assign rank_hs_in_s[r]  = rank_hs_r[r - 1];
         assign rank_cin_in_s[r] = rank_cin_r[r - 1];
      end

      // Rank register: holds partial prefix, half-sum and carry-in while the rank is occupied.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rank_pg_r[r]  <= '0;
            rank_hs_r[r]  <= '0;
            rank_cin_r[r] <= 1'b0;
         end else if (load_s[r]) begin
            rank_pg_r[r]  <= lvl_out_s[SRC];
            rank_hs_r[r]  <= rank_hs_in_s[r];
            rank_cin_r[r] <= rank_cin_in_s[r];
         end
      end
   end

   // A rank moves on unless every rank after it is full and the output is stalled,
   // which is the unrolled form of v[j] & (~v[j+1] | advance[j+1]).
   for (genvar j = 0; j < LAT; j++) begin : g_adv
      if (j == LAT - 1) begin : g_last
         assign adv_s[j] = v_r[j] & out_ready;
      end else begin : g_mid
         assign adv_s[j] = v_r[j] & ~((&v_r[LAT-1:j+1]) & ~out_ready);
      end
   end

   assign in_ready_s = ~v_r[0] | adv_s[0];
   assign load_s     = {adv_s[LAT-2:0], in_valid & in_ready_s};

   // Valid bits: set when a rank loads, cleared when its beat moves on without replacement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_r <= '0;
      end else begin
         v_r <= load_s | (v_r & ~adv_s);
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_fin
      assign fin_p_s[i] = rank_pg_r[R-1][i].p;
      assign fin_g_s[i] = rank_pg_r[R-1][i].g;
   end

   // Final carries, sum and flags from the fully resolved prefix.
   always_comb begin
      cy_s    = {fin_g_s | (fin_p_s & {N{rank_cin_r[R-1]}}), rank_cin_r[R-1]};
      sum_s   = rank_hs_r[R-1] ^ cy_s[N-1:0];
      c_out_s = cy_s[N];
      ovf_s   = cy_s[N-1] ^ cy_s[N];
      zero_s  = ~|sum_s;
   end

   // Result register: loads only when the last rank takes a beat, so it holds under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r   <= '0;
         c_out_r <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
      end else if (load_s[LAT-1]) begin
         sum_r   <= sum_s;
         c_out_r <= c_out_s;
         ovf_r   <= ovf_s;
         zero_r  <= zero_s;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = v_r[LAT-1];
   assign busy      = |v_r;
   assign sum       = sum_r;
   assign c_out     = c_out_r;
   assign ovf       = ovf_r;
   assign zero      = zero_r;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: one N=32/K=2 instance (x_) and one N=8/K=3 instance (y_),
// checked against an arithmetic model of a +/- b +/- c_in.
module tb_prefix_adder_pipe;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic        x_in_valid, x_in_ready, x_c_in, x_op_sub, x_out_valid, x_out_ready;
   logic        x_c_out, x_ovf, x_zero, x_busy;
   logic [31:0] x_a, x_b, x_sum;
   logic        y_in_valid, y_in_ready, y_c_in, y_op_sub, y_out_valid, y_out_ready;
   logic        y_c_out, y_ovf, y_zero, y_busy;
   logic [7:0]  y_a, y_b, y_sum;

   logic [34:0] xq[$];
   logic [34:0] yq[$];

   always #5 clk = ~clk;

   prefix_adder_pipe #(.N(32), .K(2)) u_x (
      .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
      .a(x_a), .b(x_b), .c_in(x_c_in), .op_sub(x_op_sub),
      .out_valid(x_out_valid), .out_ready(x_out_ready), .sum(x_sum),
      .c_out(x_c_out), .ovf(x_ovf), .zero(x_zero), .busy(x_busy)
   );

   prefix_adder_pipe #(.N(8), .K(3)) u_y (
      .clk(clk), .rst_n(rst_n), .in_valid(y_in_valid), .in_ready(y_in_ready),
      .a(y_a), .b(y_b), .c_in(y_c_in), .op_sub(y_op_sub),
      .out_valid(y_out_valid), .out_ready(y_out_ready), .sum(y_sum),
      .c_out(y_c_out), .ovf(y_ovf), .zero(y_zero), .busy(y_busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Golden model: {zero, ovf, c_out, sum} from plain integer arithmetic on n-bit operands.
   function automatic logic [34:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic sub);
      longint mask, half, ua, ub, ci, r, sa, sb, sr;
      logic [31:0] s;
      logic co, ov;
      mask = (longint'(1) << n) - 1;
      half = longint'(1) << (n - 1);
      ua = longint'(a) & mask;
      ub = longint'(b) & mask;
      ci = c ? 1 : 0;
      r  = sub ? (ua - ub - ci) : (ua + ub + ci);
      co = sub ? (r >= 0) : (r > mask);
      s  = 32'(r & mask);
      sa = (ua >= half) ? ua - (mask + 1) : ua;
      sb = (ub >= half) ? ub - (mask + 1) : ub;
      sr = sub ? (sa - sb - ci) : (sa + sb + ci);
      ov = (sr > half - 1) || (sr < -half);
      return {(s == 32'd0), ov, co, s};
   endfunction

   function automatic logic [34:0] x_res();
      return {x_zero, x_ovf, x_c_out, x_sum};
   endfunction

   function automatic logic [34:0] y_res();
      return {y_zero, y_ovf, y_c_out, 24'h0, y_sum};
   endfunction

   function automatic logic [31:0] rnd(input int n);
      logic [31:0] m;
      m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return m;
         2: return m >> 1;
         3: return (m >> 1) + 32'd1;
         4: return 32'd1;
         default: return $urandom & m;
      endcase
   endfunction

   // Scoreboard + stall-stability monitor for the N=32 instance.
   initial begin
      logic        hold_v = 1'b0;
      logic [34:0] hold_val = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            xq.delete();
            hold_v = 1'b0;
         end else begin
            if (x_in_valid && x_in_ready) xq.push_back(model(32, x_a, x_b, x_c_in, x_op_sub));
            if (hold_v) begin
               chk("x_valid_held", x_out_valid, 1'b1);
               chk("x_stall_stable", x_res(), hold_val);
            end
            if (x_out_valid && x_out_ready) begin
               chk("x_has_expected", (xq.size() != 0), 1'b1);
               if (xq.size() != 0) chk("x_result", x_res(), xq.pop_front());
            end
            hold_v   = x_out_valid && !x_out_ready;
            hold_val = x_res();
         end
      end
   end

   // Scoreboard + stall-stability monitor for the N=8 instance.
   initial begin
      logic        hold_v = 1'b0;
      logic [34:0] hold_val = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            yq.delete();
            hold_v = 1'b0;
         end else begin
            if (y_in_valid && y_in_ready)
               yq.push_back(model(8, {24'h0, y_a}, {24'h0, y_b}, y_c_in, y_op_sub));
            if (hold_v) begin
               chk("y_valid_held", y_out_valid, 1'b1);
               chk("y_stall_stable", y_res(), hold_val);
            end
            if (y_out_valid && y_out_ready) begin
               chk("y_has_expected", (yq.size() != 0), 1'b1);
               if (yq.size() != 0) chk("y_result", y_res(), yq.pop_front());
            end
            hold_v   = y_out_valid && !y_out_ready;
            hold_val = y_res();
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time %0t, required finish before 3000000", $time);
      $fatal(1, "watchdog expired");
   end

   // One isolated beat with a hand-computed result and latency.
   task automatic run_vec(input bit use_y, input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic c, input logic s,
                          input logic [34:0] exp);
      int cnt;
      chk({name, "_model"}, model(use_y ? 8 : 32, a, b, c, s), exp);
      @(posedge clk); #1;
      if (use_y) begin
         y_in_valid = 1'b1; y_a = a[7:0]; y_b = b[7:0]; y_c_in = c; y_op_sub = s;
      end else begin
         x_in_valid = 1'b1; x_a = a; x_b = b; x_c_in = c; x_op_sub = s;
      end
      @(negedge clk);
      chk({name, "_in_ready"}, use_y ? y_in_ready : x_in_ready, 1'b1);
      @(posedge clk); #1;
      x_in_valid = 1'b0;
      y_in_valid = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!(use_y ? y_out_valid : x_out_valid) && cnt < 20);
      chk({name, "_latency"}, cnt, use_y ? 2 : 4);
      chk(name, use_y ? y_res() : x_res(), exp);
   endtask

   task automatic drain(input string name);
      int cnt;
      @(posedge clk); #1;
      x_in_valid = 1'b0; y_in_valid = 1'b0;
      x_out_ready = 1'b1; y_out_ready = 1'b1;
      cnt = 0;
      while ((xq.size() != 0 || yq.size() != 0 || x_busy || y_busy) && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk({name, "_x_left"}, xq.size(), 0);
      chk({name, "_y_left"}, yq.size(), 0);
      chk({name, "_x_busy"}, x_busy, 1'b0);
      chk({name, "_y_busy"}, y_busy, 1'b0);
   endtask

   initial begin
      logic [31:0] st_a [8];
      logic [31:0] st_b [8];
      int idx, cnt, xs, ys;
      localparam int NB = 10000;

      x_in_valid = 1'b0; x_a = '0; x_b = '0; x_c_in = 1'b0; x_op_sub = 1'b0; x_out_ready = 1'b1;
      y_in_valid = 1'b0; y_a = '0; y_b = '0; y_c_in = 1'b0; y_op_sub = 1'b0; y_out_ready = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      chk("rst_x_out_valid", x_out_valid, 1'b0);
      chk("rst_x_busy", x_busy, 1'b0);
      chk("rst_x_in_ready", x_in_ready, 1'b1);
      chk("rst_x_result", x_res(), 35'd0);
      chk("rst_y_out_valid", y_out_valid, 1'b0);
      chk("rst_y_in_ready", y_in_ready, 1'b1);
      chk("rst_y_result", y_res(), 35'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      run_vec(1'b0, "add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
      run_vec(1'b0, "add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
      run_vec(1'b0, "sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});
      run_vec(1'b0, "sub_neg",  32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF});
      run_vec(1'b0, "add_cin",  32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'h2345_678A});
      run_vec(1'b0, "sub_eq",   32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
      run_vec(1'b1, "y_add_ovf", 32'h7F, 32'h01, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80});
      run_vec(1'b1, "y_sub_brw", 32'h00, 32'h00, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFF});
      run_vec(1'b1, "y_add_all", 32'hFF, 32'hFF, 1'b1, 1'b0, {1'b0, 1'b0, 1'b1, 32'hFF});
      drain("directed");

      // Reset with three beats in flight: everything clears at once, nothing emerges later.
      @(posedge clk); #1;
      x_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         x_in_valid = 1'b1; x_a = 32'd100 + 32'(i); x_b = 32'd7; x_c_in = 1'b0; x_op_sub = 1'b0;
         @(posedge clk); #1;
      end
      x_in_valid = 1'b0;
      chk("pre_rst_busy", x_busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", x_out_valid, 1'b0);
      chk("mid_rst_sum", x_sum, 32'd0);
      chk("mid_rst_busy", x_busy, 1'b0);
      chk("mid_rst_in_ready", x_in_ready, 1'b1);
      @(posedge clk); #2 rst_n = 1'b1;
      x_out_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_busy", x_busy, 1'b0);

      // Back-to-back beats into a stalled output: exactly LAT held, then in_ready drops.
      for (int i = 0; i < 8; i++) begin
         st_a[i] = 32'h1111_1111 * 32'(i + 1);
         st_b[i] = 32'h0F0F_0F0F ^ 32'(i);
      end
      x_out_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(posedge clk); #1;
         x_in_valid = (idx < 8);
         x_a = st_a[idx % 8]; x_b = st_b[idx % 8]; x_c_in = idx[0]; x_op_sub = idx[1];
         @(negedge clk);
         if (x_in_valid && x_in_ready) idx++;
      end
      chk("stall_accepted", idx, 4);
      chk("stall_in_ready", x_in_ready, 1'b0);
      chk("stall_out_valid", x_out_valid, 1'b1);
      chk("stall_busy", x_busy, 1'b1);
      cnt = 0;
      while (idx < 8 && cnt < 50) begin
         @(posedge clk); #1;
         x_out_ready = 1'b1;
         x_in_valid = 1'b1;
         x_a = st_a[idx % 8]; x_b = st_b[idx % 8]; x_c_in = idx[0]; x_op_sub = idx[1];
         @(negedge clk);
         if (x_in_valid && x_in_ready) idx++;
         cnt++;
      end
      chk("stall_all_sent", idx, 8);
      drain("stall");

      // Random traffic on both instances with random valid/ready.
      xs = 0; ys = 0; cnt = 0;
      while ((xs < NB || ys < NB) && cnt < 60000) begin
         @(posedge clk); #1;
         x_out_ready = ($urandom_range(0, 3) != 0);
         y_out_ready = ($urandom_range(0, 3) != 0);
         x_in_valid  = (xs < NB) && ($urandom_range(0, 3) != 0);
         y_in_valid  = (ys < NB) && ($urandom_range(0, 3) != 0);
         x_a = rnd(32); x_b = rnd(32); x_c_in = 1'($urandom); x_op_sub = 1'($urandom);
         y_a = 8'(rnd(8)); y_b = 8'(rnd(8)); y_c_in = 1'($urandom); y_op_sub = 1'($urandom);
         @(negedge clk);
         if (x_in_valid && x_in_ready) xs++;
         if (y_in_valid && y_in_ready) ys++;
         cnt++;
      end
      chk("rand_x_beats", xs, NB);
      chk("rand_y_beats", ys, NB);
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
